ir: RTL and testbench



---
 rtl/ir.sv | 63 ++++++
 tb/tb_ir.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ir.sv
// rtl/ir.sv - instruction register with opcode/operand split and one-hot opcode decode
//
// Captures the fetched instruction word on load and holds it for the rest of
// the instruction cycle. The field split and decode are combinational from the
// stored word so the controller sees them in the same cycle as data_out.
// Default opcode map (decode naming only, nothing here acts on it):
//   0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.

module ir #(
   parameter int WIDTH   = 8,
   parameter int OP_BITS = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH-1:0]            data_in,
   input  logic                        load,
   output logic [WIDTH-1:0]            data_out,
   output logic [OP_BITS-1:0]          opcode,
   output logic [WIDTH-OP_BITS-1:0]    operand,
   output logic [(1 << OP_BITS)-1:0]   op_onehot,
   output logic                        valid
);

   logic [WIDTH-1:0] ir_q;
   logic [WIDTH-1:0] ir_d;
   logic             valid_q;
   logic             valid_d;

   // Next state: capture the bus word on load, otherwise hold. Gating on load
   // keeps unknowns on the idle bus out of the register.
   always_comb begin
      ir_d    = ir_q;
      valid_d = valid_q;
      if (load) begin
         ir_d    = data_in;
         valid_d = 1'b1;
      end
   end

   // State register; reset clears immediately and overrides any load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         valid_q <= valid_d;
      end
   end

   assign data_out = ir_q;
   assign valid    = valid_q;
   assign opcode   = ir_q[WIDTH-1 -: OP_BITS];
   assign operand  = ir_q[WIDTH-OP_BITS-1:0];

   // One-hot opcode decode; a cleared register decodes to bit 0 (HLT), so the
   // controller must qualify this with valid.
   always_comb begin
      op_onehot         = '0;
      op_onehot[opcode] = 1'b1;
   end

endmodule

// File: tb/tb_ir.sv
// tb/tb_ir.sv - self-checking bench for ir: directed plan then randomized run against a reference model

module tb_ir;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       load = 1'b0;
   logic [7:0] data_out;
   logic [2:0] opcode;
   logic [4:0] operand;
   logic [7:0] op_onehot;
   logic       valid;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] exp_ir    = 8'h00;
   logic       exp_valid = 1'b0;

   ir #(.WIDTH(8), .OP_BITS(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .load      (load),
      .data_out  (data_out),
      .opcode    (opcode),
      .operand   (operand),
      .op_onehot (op_onehot),
      .valid     (valid)
   );

   always #5 clk = ~clk;

   task automatic cmp8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Compare every output against the model's word, derived field by field.
   task automatic check(input string tag);
      logic [2:0] e_op;
      logic [7:0] e_oh;
      e_op = exp_ir / 8'd32;
      e_oh = 8'd1 << e_op;
      cmp8({tag, ".data_out"},  data_out,          exp_ir);
      cmp8({tag, ".opcode"},    {5'd0, opcode},    {5'd0, e_op});
      cmp8({tag, ".operand"},   {3'd0, operand},   exp_ir % 8'd32);
      cmp8({tag, ".op_onehot"}, op_onehot,         e_oh);
      cmp8({tag, ".valid"},     {7'd0, valid},     {7'd0, exp_valid});
   endtask

   // Drive inputs at the falling edge; an asserted reset clears the model at once.
   task automatic apply(input logic r, input logic l, input logic [7:0] d);
      @(negedge clk);
      rst     = r;
      load    = l;
      data_in = d;
      if (r) begin
         exp_ir    = 8'h00;
         exp_valid = 1'b0;
      end
   endtask

   // Advance one rising edge, update the model, sample just after the edge.
   task automatic edge_check(input string tag);
      if (!rst && load) begin
         exp_ir    = data_in;
         exp_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      check(tag);
   endtask

   initial begin
      logic [7:0] hold_pat [2];
      logic [7:0] b2b [3];
      hold_pat[0] = 8'h00;
      hold_pat[1] = 8'hFF;
      b2b[0] = 8'hE1;
      b2b[1] = 8'h3F;
      b2b[2] = 8'h40;

      // Reset with no clock edge, load high and bus all ones.
      #1;
      data_in = 8'hFF;
      load    = 1'b1;
      rst     = 1'b1;
      #2;
      check("reset_noclk");
      @(posedge clk);
      #1;
      check("reset_edge");

      // Single load.
      apply(1'b0, 1'b1, 8'hA5);
      edge_check("load_a5");

      // Hold while the bus toggles, including an unknown bus.
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 1'b0, hold_pat[i % 2]);
         edge_check($sformatf("hold%0d", i));
      end
      apply(1'b0, 1'b0, 8'hxx);
      edge_check("hold_x");

      // Back-to-back loads.
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1, b2b[i]);
         edge_check($sformatf("b2b%0d", i));
      end

      // Asynchronous reset pulse between edges.
      @(negedge clk);
      load = 1'b0;
      #2;
      rst       = 1'b1;
      exp_ir    = 8'h00;
      exp_valid = 1'b0;
      #1;
      check("async_mid");
      #1;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b0, 8'h5A);
         edge_check($sformatf("after_async%0d", i));
      end

      // Reset and load together, then first load after release.
      apply(1'b1, 1'b1, 8'h77);
      edge_check("rst_load0");
      edge_check("rst_load1");
      apply(1'b0, 1'b1, 8'h77);
      edge_check("first_load");

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 300; i++) begin
         apply($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
         if (rst) begin
            #1;
            check($sformatf("rand_rst%0d", i));
         end
         edge_check($sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
